// File: rtl/id_pipe_if.sv
// id_pipe_if: handshake and decode bus between if_id, the regfile, id_pipe and ex.
interface id_pipe_if #(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 64,
    parameter int REG_AW = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       inst_i;
    logic [ADDR_W-1:0] inst_addr_i;
    logic              flush_i;
    logic [REG_AW-1:0] reg1_raddr_o;
    logic [REG_AW-1:0] reg2_raddr_o;
    logic [XLEN-1:0]   reg1_rdata_i;
    logic [XLEN-1:0]   reg2_rdata_i;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   op1_o;
    logic [XLEN-1:0]   op2_o;
    logic [XLEN-1:0]   imm_o;
    logic [31:0]       inst_o;
    logic [ADDR_W-1:0] inst_addr_o;
    logic [XLEN-1:0]   reg1_rdata_o;
    logic [XLEN-1:0]   reg2_rdata_o;
    logic              reg_we_o;
    logic [REG_AW-1:0] reg_waddr_o;
    logic              illegal_o;

    modport slave (
        input  in_valid, inst_i, inst_addr_i, flush_i, reg1_rdata_i, reg2_rdata_i, out_ready,
        output in_ready, reg1_raddr_o, reg2_raddr_o, out_valid, op1_o, op2_o, imm_o, inst_o,
               inst_addr_o, reg1_rdata_o, reg2_rdata_o, reg_we_o, reg_waddr_o, illegal_o
    );

    modport master (
        output in_valid, inst_i, inst_addr_i, flush_i, reg1_rdata_i, reg2_rdata_i, out_ready,
        input  in_ready, reg1_raddr_o, reg2_raddr_o, out_valid, op1_o, op2_o, imm_o, inst_o,
               inst_addr_o, reg1_rdata_o, reg2_rdata_o, reg_we_o, reg_waddr_o, illegal_o
    );
endinterface

// File: rtl/id_pipe.sv
// id_pipe: registered RV32I/RV64I decode stage with valid/ready handshake and flush.
module id_pipe #(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 64,
    parameter int REG_AW = 5
) (
    input logic      clk,
    input logic      rst,
    id_pipe_if.slave bus
);
    typedef struct packed {
        logic [XLEN-1:0]   op1;
        logic [XLEN-1:0]   op2;
        logic [XLEN-1:0]   imm;
        logic [XLEN-1:0]   r1;
        logic [XLEN-1:0]   r2;
        logic [31:0]       inst;
        logic [ADDR_W-1:0] pc;
        logic              we;
        logic [REG_AW-1:0] wa;
        logic              ill;
    } bundle_t;

    bundle_t         b_d, b_q;
    logic            valid_q, ld, use1, use2, we, ld_ok, st_ok;
    logic [6:0]      opc;
    logic [2:0]      f3;
    logic [4:0]      rd;
    logic [XLEN-1:0] pc, four, imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opc   = bus.inst_i[6:0];
    assign f3    = bus.inst_i[14:12];
    assign rd    = bus.inst_i[11:7];
    assign pc    = XLEN'(bus.inst_addr_i);
    assign four  = XLEN'(3'd4);
    assign imm_i = XLEN'($signed(bus.inst_i[31:20]));
    assign imm_s = XLEN'($signed({bus.inst_i[31:25], bus.inst_i[11:7]}));
    assign imm_b = XLEN'($signed({bus.inst_i[31], bus.inst_i[7], bus.inst_i[30:25], bus.inst_i[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({bus.inst_i[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({bus.inst_i[31], bus.inst_i[19:12], bus.inst_i[20], bus.inst_i[30:21], 1'b0}));
    // RV32 has no LWU/LD/SD, so the legal LOAD/STORE funct3 sets shrink
    assign ld_ok = (XLEN == 32) ? (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) : (f3 != 3'b111);
    assign st_ok = f3 <= ((XLEN == 32) ? 3'd2 : 3'd3);

    always_comb begin
        b_d      = '0;
        use1     = 1'b0;
        use2     = 1'b0;
        we       = 1'b0;
        b_d.inst = bus.inst_i;
        b_d.pc   = bus.inst_addr_i;
        b_d.r1   = bus.reg1_rdata_i;
        b_d.r2   = bus.reg2_rdata_i;
        case (opc)
            7'b0010011: begin use1 = 1'b1; b_d.op1 = bus.reg1_rdata_i; b_d.op2 = imm_i; b_d.imm = imm_i; we = 1'b1; end
            7'b0110011: begin use1 = 1'b1; use2 = 1'b1; b_d.op1 = bus.reg1_rdata_i; b_d.op2 = bus.reg2_rdata_i; we = 1'b1; end
            7'b0110111: begin b_d.op2 = imm_u; b_d.imm = imm_u; we = 1'b1; end
            7'b0010111: begin b_d.op1 = pc; b_d.op2 = imm_u; b_d.imm = imm_u; we = 1'b1; end
            7'b1101111: begin b_d.op1 = pc; b_d.op2 = four; b_d.imm = imm_j; we = 1'b1; end
            7'b1100111:
                if (f3 == 3'b000) begin use1 = 1'b1; b_d.op1 = pc; b_d.op2 = four; b_d.imm = imm_i; we = 1'b1; end
                else b_d.ill = 1'b1;
            7'b1100011:
                if (f3[2:1] != 2'b01) begin
                    use1 = 1'b1; use2 = 1'b1; b_d.op1 = bus.reg1_rdata_i; b_d.op2 = bus.reg2_rdata_i; b_d.imm = imm_b;
                end else b_d.ill = 1'b1;
            7'b0000011:
                if (ld_ok) begin use1 = 1'b1; b_d.op1 = bus.reg1_rdata_i; b_d.op2 = imm_i; b_d.imm = imm_i; we = 1'b1; end
                else b_d.ill = 1'b1;
            7'b0100011:
                if (st_ok) begin use1 = 1'b1; use2 = 1'b1; b_d.op1 = bus.reg1_rdata_i; b_d.op2 = imm_s; b_d.imm = imm_s; end
                else b_d.ill = 1'b1;
            default: b_d.ill = 1'b1;
        endcase
        b_d.we = we && (rd != 5'd0);
        b_d.wa = b_d.we ? REG_AW'(rd) : '0;
    end

    assign bus.reg1_raddr_o = use1 ? REG_AW'(bus.inst_i[19:15]) : '0;
    assign bus.reg2_raddr_o = use2 ? REG_AW'(bus.inst_i[24:20]) : '0;
    assign bus.in_ready     = !valid_q || bus.out_ready;
    assign ld               = bus.in_valid && bus.in_ready && !bus.flush_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            b_q     <= '0;
        end else begin
            valid_q <= bus.flush_i ? 1'b0 : ld ? 1'b1 : bus.out_ready ? 1'b0 : valid_q;
            if (ld) b_q <= b_d;
        end
    end

    assign bus.out_valid    = valid_q;
    assign bus.op1_o        = b_q.op1;
    assign bus.op2_o        = b_q.op2;
    assign bus.imm_o        = b_q.imm;
    assign bus.inst_o       = b_q.inst;
    assign bus.inst_addr_o  = b_q.pc;
    assign bus.reg1_rdata_o = b_q.r1;
    assign bus.reg2_rdata_o = b_q.r2;
    assign bus.reg_we_o     = b_q.we;
    assign bus.reg_waddr_o  = b_q.wa;
    assign bus.illegal_o    = b_q.ill;
endmodule

// File: tb/tb_id_pipe.sv
// tb_id_pipe: checks XLEN=64 and XLEN=32 decode stages side by side against an arithmetic reference model.
module tb_id_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_pass = 0;

    id_pipe_if #(.XLEN(64), .ADDR_W(64), .REG_AW(5)) f64 ();
    id_pipe_if #(.XLEN(32), .ADDR_W(32), .REG_AW(5)) f32 ();

    id_pipe #(.XLEN(64), .ADDR_W(64), .REG_AW(5)) dut64 (.clk(clk), .rst(rst), .bus(f64));
    id_pipe #(.XLEN(32), .ADDR_W(32), .REG_AW(5)) dut32 (.clk(clk), .rst(rst), .bus(f32));

    assign f32.in_valid     = f64.in_valid;
    assign f32.inst_i       = f64.inst_i;
    assign f32.inst_addr_i  = f64.inst_addr_i[31:0];
    assign f32.flush_i      = f64.flush_i;
    assign f32.reg1_rdata_i = f64.reg1_rdata_i[31:0];
    assign f32.reg2_rdata_i = f64.reg2_rdata_i[31:0];
    assign f32.out_ready    = f64.out_ready;

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] op1, op2, imm;
        logic        we, ill;
        logic [4:0]  wa, ra1, ra2;
    } dec_t;

    typedef struct packed {
        logic        v;
        logic [63:0] op1, op2, imm, r1, r2, pc;
        logic [31:0] ins;
        logic        we, ill;
        logic [4:0]  wa;
    } st_t;

    st_t st[2];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
        else n_pass++;
    endtask

    function automatic dec_t dec(input logic [31:0] w, input logic [63:0] pc, input logic [63:0] r1,
                                 input logic [63:0] r2, input bit x32);
        dec_t d;
        logic [2:0] f;
        bit ok;
        longint ii, is, ib, iu, ij;
        f  = w[14:12];
        ii = longint'($signed(w[31:20]));
        is = longint'($signed({w[31:25], w[11:7]}));
        ib = longint'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
        iu = longint'($signed(w[31:12])) * 64'sd4096;
        ij = longint'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
        d  = '0;
        ok = 1'b1;
        case (w[6:0])
            7'h13: begin d.ra1 = w[19:15]; d.op1 = r1; d.op2 = ii; d.imm = ii; d.we = 1; end
            7'h33: begin d.ra1 = w[19:15]; d.ra2 = w[24:20]; d.op1 = r1; d.op2 = r2; d.we = 1; end
            7'h37: begin d.op2 = iu; d.imm = iu; d.we = 1; end
            7'h17: begin d.op1 = pc; d.op2 = iu; d.imm = iu; d.we = 1; end
            7'h6f: begin d.op1 = pc; d.op2 = 4; d.imm = ij; d.we = 1; end
            7'h67: begin ok = (f == 0); d.ra1 = w[19:15]; d.op1 = pc; d.op2 = 4; d.imm = ii; d.we = 1; end
            7'h63: begin ok = !(f inside {3'd2, 3'd3}); d.ra1 = w[19:15]; d.ra2 = w[24:20]; d.op1 = r1; d.op2 = r2; d.imm = ib; end
            7'h03: begin ok = x32 ? (f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f != 7); d.ra1 = w[19:15]; d.op1 = r1; d.op2 = ii; d.imm = ii; d.we = 1; end
            7'h23: begin ok = f <= (x32 ? 3'd2 : 3'd3); d.ra1 = w[19:15]; d.ra2 = w[24:20]; d.op1 = r1; d.op2 = is; d.imm = is; end
            default: ok = 1'b0;
        endcase
        if (!ok) d = '0;
        d.ill = !ok;
        if (w[11:7] == 0) d.we = 0;
        d.wa = d.we ? w[11:7] : 5'd0;
        if (x32) begin
            d.op1 = {32'd0, d.op1[31:0]};
            d.op2 = {32'd0, d.op2[31:0]};
            d.imm = {32'd0, d.imm[31:0]};
        end
        return d;
    endfunction

    function automatic logic [63:0] msk(input logic [63:0] v, input int k);
        return k == 1 ? {32'd0, v[31:0]} : v;
    endfunction

    function automatic dec_t dec_k(input int k);
        return dec(f64.inst_i, msk(f64.inst_addr_i, k), msk(f64.reg1_rdata_i, k), msk(f64.reg2_rdata_i, k), k == 1);
    endfunction

    task automatic cmp(input string p, input int k, input logic v, input logic [63:0] op1, input logic [63:0] op2,
                       input logic [63:0] imm, input logic [63:0] r1, input logic [63:0] r2, input logic [63:0] pc,
                       input logic [31:0] ins, input logic we, input logic ill, input logic [4:0] wa);
        chk({p, "_valid"}, 64'(v), 64'(st[k].v));
        chk({p, "_op1"}, op1, st[k].op1);
        chk({p, "_op2"}, op2, st[k].op2);
        chk({p, "_imm"}, imm, st[k].imm);
        chk({p, "_r1"}, r1, st[k].r1);
        chk({p, "_r2"}, r2, st[k].r2);
        chk({p, "_pc"}, pc, st[k].pc);
        chk({p, "_inst"}, 64'(ins), 64'(st[k].ins));
        chk({p, "_we"}, 64'(we), 64'(st[k].we));
        chk({p, "_ill"}, 64'(ill), 64'(st[k].ill));
        chk({p, "_waddr"}, 64'(wa), 64'(st[k].wa));
    endtask

    task automatic cyc();
        dec_t d;
        bit ir, ld;
        #1;
        for (int k = 0; k < 2; k++) begin
            d = dec_k(k);
            chk(k ? "x32_ra1" : "x64_ra1", 64'(k ? f32.reg1_raddr_o : f64.reg1_raddr_o), 64'(d.ra1));
            chk(k ? "x32_ra2" : "x64_ra2", 64'(k ? f32.reg2_raddr_o : f64.reg2_raddr_o), 64'(d.ra2));
            if (!rst) chk(k ? "x32_in_ready" : "x64_in_ready", 64'(k ? f32.in_ready : f64.in_ready),
                          64'(!st[k].v || f64.out_ready));
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            d  = dec_k(k);
            ir = !st[k].v || f64.out_ready;
            ld = f64.in_valid && ir && !f64.flush_i;
            if (rst) st[k] = '0;
            else begin
                if (ld) begin
                    st[k].op1 = d.op1; st[k].op2 = d.op2; st[k].imm = d.imm;
                    st[k].r1 = msk(f64.reg1_rdata_i, k); st[k].r2 = msk(f64.reg2_rdata_i, k);
                    st[k].pc = msk(f64.inst_addr_i, k); st[k].ins = f64.inst_i;
                    st[k].we = d.we; st[k].ill = d.ill; st[k].wa = d.wa;
                end
                st[k].v = f64.flush_i ? 1'b0 : ld ? 1'b1 : f64.out_ready ? 1'b0 : st[k].v;
            end
        end
        #1;
        cmp("x64", 0, f64.out_valid, f64.op1_o, f64.op2_o, f64.imm_o, f64.reg1_rdata_o, f64.reg2_rdata_o,
            f64.inst_addr_o, f64.inst_o, f64.reg_we_o, f64.illegal_o, f64.reg_waddr_o);
        cmp("x32", 1, f32.out_valid, 64'(f32.op1_o), 64'(f32.op2_o), 64'(f32.imm_o), 64'(f32.reg1_rdata_o),
            64'(f32.reg2_rdata_o), 64'(f32.inst_addr_o), f32.inst_o, f32.reg_we_o, f32.illegal_o, f32.reg_waddr_o);
    endtask

    task automatic drive(input logic v, input logic [31:0] w, input logic rdy, input logic fl);
        f64.in_valid     = v;
        f64.inst_i       = w;
        f64.out_ready    = rdy;
        f64.flush_i      = fl;
        f64.inst_addr_i  = {$urandom, $urandom};
        f64.reg1_rdata_i = {$urandom, $urandom};
        f64.reg2_rdata_i = {$urandom, $urandom};
    endtask

    logic [6:0] opcs[9] = '{7'h13, 7'h33, 7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23};

    initial begin
        st[0] = '0;
        st[1] = '0;
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        chk("reset_valid", 64'(f64.out_valid), 64'd0);
        // addi x5,x1,-1
        drive(1'b1, 32'hFFF08293, 1'b1, 1'b0);
        f64.reg1_rdata_i = 64'h10;
        #1;
        chk("addi_ra1", 64'(f64.reg1_raddr_o), 64'd1);
        cyc();
        chk("addi_valid", 64'(f64.out_valid), 64'd1);
        chk("addi_op1", f64.op1_o, 64'h10);
        chk("addi_op2", f64.op2_o, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("addi_imm", f64.imm_o, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("addi_we", 64'(f64.reg_we_o), 64'd1);
        chk("addi_waddr", 64'(f64.reg_waddr_o), 64'd5);
        // lui x3,0x80000
        drive(1'b1, 32'h800001B7, 1'b1, 1'b0);
        cyc();
        chk("lui_op1", f64.op1_o, 64'd0);
        chk("lui_op2", f64.op2_o, 64'hFFFF_FFFF_8000_0000);
        chk("lui32_op2", 64'(f32.op2_o), 64'h8000_0000);
        chk("lui_waddr", 64'(f64.reg_waddr_o), 64'd3);
        // beq x1,x2,-4
        drive(1'b1, 32'hFE208EE3, 1'b1, 1'b0);
        cyc();
        chk("beq_ra1", 64'(f64.reg1_raddr_o), 64'd1);
        chk("beq_ra2", 64'(f64.reg2_raddr_o), 64'd2);
        chk("beq_imm", f64.imm_o, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("beq_we", 64'(f64.reg_we_o), 64'd0);
        chk("beq_ill", 64'(f64.illegal_o), 64'd0);
        // backpressure: beq held while addi x6 waits
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h00108313, 1'b0, 1'b0);
            cyc();
            chk("bp_in_ready", 64'(f64.in_ready), 64'd0);
            chk("bp_hold", 64'(f64.inst_o), 64'hFE208EE3);
        end
        drive(1'b1, 32'h00108313, 1'b1, 1'b0);
        cyc();
        chk("bp_release", 64'(f64.inst_o), 64'h00108313);
        chk("bp_release_valid", 64'(f64.out_valid), 64'd1);
        // flush while stalled with a pending input
        drive(1'b1, 32'h002081B3, 1'b0, 1'b1);
        cyc();
        chk("flush_valid", 64'(f64.out_valid), 64'd0);
        drive(1'b0, 32'h002081B3, 1'b1, 1'b0);
        cyc();
        chk("flush_after", 64'(f64.out_valid), 64'd0);
        // illegal all-zero word
        drive(1'b1, 32'h0, 1'b1, 1'b0);
        cyc();
        chk("ill_flag", 64'(f64.illegal_o), 64'd1);
        chk("ill_we", 64'(f64.reg_we_o), 64'd0);
        chk("ill_op1", f64.op1_o, 64'd0);
        chk("ill_op2", f64.op2_o, 64'd0);
        // reset mid-stall
        drive(1'b1, 32'hFFF08293, 1'b1, 1'b0);
        cyc();
        drive(1'b1, 32'h800001B7, 1'b0, 1'b0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rst_valid", 64'(f64.out_valid), 64'd0);
        chk("rst_op1", f64.op1_o, 64'd0);
        chk("rst_inst", 64'(f64.inst_o), 64'd0);
        chk("rst_r1", f64.reg1_rdata_o, 64'd0);
        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] w;
            int sel;
            sel = $urandom_range(0, 9);
            w = $urandom;
            if (sel < 9) w[6:0] = opcs[sel];
            if ($urandom_range(0, 7) == 0) w[11:7] = 5'd0;
            if (sel == 5 && $urandom_range(0, 1) == 1) w[14:12] = 3'd0;
            drive($urandom_range(0, 3) != 0, w, $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
            rst = ($urandom_range(0, 99) == 0);
            cyc();
        end
        rst = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
